// File: rtl/lvds_train_ctrl.sv
// lvds_train_ctrl
// Link-training controller for the 6-bit LVDS port. Once the PLL has been
// locked long enough, it sweeps the RX sample-delay tap, checks the received
// training pattern at each tap and parks the tap in the middle of the first
// contiguous good window. The TX training pattern free-runs throughout; on
// success the TX port is handed back to the datapath.
//
// Build option: LVDS_TRAIN_RETRAIN_EN adds the `retrain` input, which restarts
// training from DONE or FAIL.
//
// Ports:
//   clk            in   fabric clock
//   reset_b        in   asynchronous active-low reset
//   locked         in   PLL lock (asynchronous, synchronised here)
//   retrain        in   retrain pulse (only with LVDS_TRAIN_RETRAIN_EN)
//   rx_frame       in   received frame bit
//   rx_d[5:0]      in   received data
//   tap_sel        out  RX sample-delay select
//   tx_src         out  0 = TX training pattern, 1 = TX datapath
//   tx_train_frame out  training frame bit
//   tx_train_d     out  training data
//   train_done     out  high while in DONE
//   train_fail     out  high while in FAIL
//
// state     | meaning
// WAIT_LOCK | counting consecutive synced lock cycles
// SETTLE    | letting the RX path settle after a tap change
// CHECK     | comparing received pattern at the current tap
// EVAL      | picking the centre of the first good window
// DONE      | trained, TX handed to datapath
// FAIL      | no good tap found

module lvds_train_ctrl #(
    parameter int         TAP_W      = 5,
    parameter int         LOCK_CYC   = 256,
    parameter int         SETTLE_CYC = 16,
    parameter int         CHECK_CYC  = 1024,
    parameter logic [5:0] PATTERN    = 6'h2A
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             locked,
`ifdef LVDS_TRAIN_RETRAIN_EN
    input  logic             retrain,
`endif
    input  logic             rx_frame,
    input  logic [5:0]       rx_d,
    output logic [TAP_W-1:0] tap_sel,
    output logic             tx_src,
    output logic             tx_train_frame,
    output logic [5:0]       tx_train_d,
    output logic             train_done,
    output logic             train_fail
);

    localparam int CNT_MAX = (LOCK_CYC > SETTLE_CYC)
                           ? ((LOCK_CYC > CHECK_CYC) ? LOCK_CYC : CHECK_CYC)
                           : ((SETTLE_CYC > CHECK_CYC) ? SETTLE_CYC : CHECK_CYC);
    localparam int CNT_W = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] LOAD_LOCK   = CNT_W'(LOCK_CYC - 1);
    localparam logic [CNT_W-1:0] LOAD_SETTLE = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] LOAD_CHECK  = CNT_W'(CHECK_CYC - 1);
    localparam logic [TAP_W-1:0] TAP_MAX     = '1;

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_SETTLE,
        S_CHECK,
        S_EVAL,
        S_DONE,
        S_FAIL
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_tx_src_nxt;
    logic             w_done_nxt;
    logic             w_fail_nxt;
    logic             r_tx_src;
    logic             r_done;
    logic             r_fail;

    logic             r_lock_s1;
    logic             r_lock_s2;
    logic             w_retrain;

    logic             r_tx_frame;
    logic [5:0]       r_tx_d;

    logic             r_q1_f;
    logic             r_q2_f;
    logic [5:0]       r_q1_d;
    logic [5:0]       w_exp_d;
    logic             w_err;
    logic             w_bad;

    logic [CNT_W-1:0] r_cnt;
    logic             r_err_flag;
    logic [TAP_W-1:0] r_tap;
    logic [TAP_W-1:0] r_first;
    logic [TAP_W-1:0] r_last;
    logic             r_open;
    logic             r_closed;
    logic             w_found;
    logic             w_cnt_zero;
    logic             w_restart;

`ifdef LVDS_TRAIN_RETRAIN_EN
    assign w_retrain = retrain;
`else
    assign w_retrain = 1'b0;
`endif

    assign w_exp_d    = r_q1_f ? PATTERN : ~PATTERN;
    assign w_err      = (r_q1_f == r_q2_f) || (r_q1_d != w_exp_d);
    assign w_bad      = r_err_flag | w_err;
    assign w_found    = r_open | r_closed;
    assign w_cnt_zero = (r_cnt == '0);
    // Any exit back to WAIT_LOCK from another state (lock loss or retrain).
    assign w_restart  = (r_state != S_WAIT_LOCK) && (w_state_nxt == S_WAIT_LOCK);

    // State register (outputs registered alongside so they track the state).
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state  <= S_WAIT_LOCK;
            r_tx_src <= 1'b0;
            r_done   <= 1'b0;
            r_fail   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tx_src <= w_tx_src_nxt;
            r_done   <= w_done_nxt;
            r_fail   <= w_fail_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_WAIT_LOCK: if (r_lock_s2 && w_cnt_zero) w_state_nxt = S_SETTLE;
            S_SETTLE:    if (w_cnt_zero) w_state_nxt = S_CHECK;
            S_CHECK:     if (w_cnt_zero) w_state_nxt = (r_tap == TAP_MAX) ? S_EVAL : S_SETTLE;
            S_EVAL:      w_state_nxt = w_found ? S_DONE : S_FAIL;
            S_DONE:      if (w_retrain) w_state_nxt = S_WAIT_LOCK;
            S_FAIL:      if (w_retrain) w_state_nxt = S_WAIT_LOCK;
            default:     w_state_nxt = S_WAIT_LOCK;
        endcase
        if (r_state != S_WAIT_LOCK && !r_lock_s2) begin
            w_state_nxt = S_WAIT_LOCK;
        end
    end

    // Output logic (next values of the registered outputs).
    always_comb begin
        w_tx_src_nxt = (w_state_nxt == S_DONE);
        w_done_nxt   = (w_state_nxt == S_DONE);
        w_fail_nxt   = (w_state_nxt == S_FAIL);
    end

    // Lock synchroniser, TX pattern generator, RX capture pipeline.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_lock_s1  <= 1'b0;
            r_lock_s2  <= 1'b0;
            r_tx_frame <= 1'b0;
            r_tx_d     <= 6'h00;
            r_q1_f     <= 1'b0;
            r_q2_f     <= 1'b0;
            r_q1_d     <= 6'h00;
        end else begin
            r_lock_s1  <= locked;
            r_lock_s2  <= r_lock_s1;
            r_tx_frame <= ~r_tx_frame;
            // Data follows the frame value being loaded this edge.
            r_tx_d     <= r_tx_frame ? ~PATTERN : PATTERN;
            r_q1_f     <= rx_frame;
            r_q2_f     <= r_q1_f;
            r_q1_d     <= rx_d;
        end
    end

    // Timer, tap select and good-window tracker.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_cnt      <= LOAD_LOCK;
            r_err_flag <= 1'b0;
            r_tap      <= '0;
            r_first    <= '0;
            r_last     <= '0;
            r_open     <= 1'b0;
            r_closed   <= 1'b0;
        end else if (w_restart) begin
            r_cnt <= LOAD_LOCK;
        end else begin
            unique case (r_state)
                S_WAIT_LOCK: begin
                    if (!r_lock_s2) begin
                        r_cnt <= LOAD_LOCK;
                    end else if (w_cnt_zero) begin
                        r_cnt    <= LOAD_SETTLE;
                        r_tap    <= '0;
                        r_first  <= '0;
                        r_last   <= '0;
                        r_open   <= 1'b0;
                        r_closed <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (w_cnt_zero) begin
                        r_cnt      <= LOAD_CHECK;
                        r_err_flag <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    r_err_flag <= w_bad;
                    if (w_cnt_zero) begin
                        if (!w_bad && !r_closed) begin
                            if (!r_open) r_first <= r_tap;
                            r_last <= r_tap;
                            r_open <= 1'b1;
                        end else if (w_bad && r_open) begin
                            r_open   <= 1'b0;
                            r_closed <= 1'b1;
                        end
                        if (r_tap != TAP_MAX) begin
                            r_tap <= r_tap + 1'b1;
                            r_cnt <= LOAD_SETTLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_EVAL: begin
                    r_tap <= w_found ? (r_first + ((r_last - r_first) >> 1)) : '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign tap_sel        = r_tap;
    assign tx_src         = r_tx_src;
    assign tx_train_frame = r_tx_frame;
    assign tx_train_d     = r_tx_d;
    assign train_done     = r_done;
    assign train_fail     = r_fail;

endmodule

// File: tb/tb_lvds_train_ctrl.sv
module tb_lvds_train_ctrl;

    localparam int         TAP_W      = 3;
    localparam int         NTAPS      = 8;
    localparam int         LOCK_CYC   = 4;
    localparam int         SETTLE_CYC = 2;
    localparam int         CHECK_CYC  = 8;
    localparam logic [5:0] PAT        = 6'h2A;
    localparam int         MIN_TRAIN  = LOCK_CYC + NTAPS * (SETTLE_CYC + CHECK_CYC) + 1;
    localparam int         SLACK      = 12;

    logic             clk = 1'b0;
    logic             reset_b;
    logic             locked;
    logic             rx_frame;
    logic [5:0]       rx_d;
    logic [TAP_W-1:0] tap_sel;
    logic             tx_src;
    logic             tx_train_frame;
    logic [5:0]       tx_train_d;
    logic             train_done;
    logic             train_fail;
`ifdef LVDS_TRAIN_RETRAIN_EN
    logic             retrain;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] bad_mask = 8'h00;
    logic [7:0] bad_mode = 8'h00;

    lvds_train_ctrl #(
        .TAP_W(TAP_W), .LOCK_CYC(LOCK_CYC), .SETTLE_CYC(SETTLE_CYC),
        .CHECK_CYC(CHECK_CYC), .PATTERN(PAT)
    ) dut (
        .clk(clk),
        .reset_b(reset_b),
        .locked(locked),
`ifdef LVDS_TRAIN_RETRAIN_EN
        .retrain(retrain),
`endif
        .rx_frame(rx_frame),
        .rx_d(rx_d),
        .tap_sel(tap_sel),
        .tx_src(tx_src),
        .tx_train_frame(tx_train_frame),
        .tx_train_d(tx_train_d),
        .train_done(train_done),
        .train_fail(train_fail)
    );

    always #5 clk = ~clk;

    // RX driver: loopback of the TX pattern, corrupted at taps marked bad.
    // Mode 0 corrupts data bits, mode 1 freezes the frame bit.
    initial begin
        rx_frame = 1'b0;
        rx_d     = 6'h00;
        forever begin
            @(negedge clk);
            if (bad_mask[tap_sel]) begin
                if (bad_mode[tap_sel]) begin
                    rx_frame = 1'b1;
                    rx_d     = PAT;
                end else begin
                    rx_frame = tx_train_frame;
                    rx_d     = tx_train_d ^ 6'($urandom_range(1, 63));
                end
            end else begin
                rx_frame = tx_train_frame;
                rx_d     = tx_train_d;
            end
        end
    end

    // Reference: centre of the first contiguous run of good taps.
    function automatic int model_tap(input logic [7:0] bad, output bit ok);
        int first = -1;
        int last  = -1;
        for (int t = 0; t < NTAPS; t++) begin
            if (!bad[t]) begin
                if (first < 0) first = t;
                last = t;
            end else if (first >= 0) begin
                break;
            end
        end
        ok = (first >= 0);
        return ok ? first + (last - first) / 2 : 0;
    endfunction

    task automatic do_reset();
        reset_b = 1'b0;
        locked  = 1'b0;
`ifdef LVDS_TRAIN_RETRAIN_EN
        retrain = 1'b0;
`endif
        bad_mask = 8'h00;
        bad_mode = 8'h00;
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_end(output int cyc, output bit to);
        cyc = 0;
        to  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cyc++;
            if (train_done || train_fail) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        locked  = 1'b0;
`ifdef LVDS_TRAIN_RETRAIN_EN
        retrain = 1'b0;
`endif
        #1;
        @(negedge clk);
        checks++; if (tap_sel !== 3'd0) begin errors++; $display("FAIL reset_tap: got %0d expected 0", tap_sel); end
        checks++; if (tx_src !== 1'b0) begin errors++; $display("FAIL reset_tx_src: got %b expected 0", tx_src); end
        checks++; if (tx_train_frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b expected 0", tx_train_frame); end
        checks++; if (tx_train_d !== 6'h00) begin errors++; $display("FAIL reset_tx_d: got %h expected 00", tx_train_d); end
        checks++; if (train_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", train_done); end
        checks++; if (train_fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b expected 0", train_fail); end
        reset_b = 1'b1;
    endtask

    task automatic test_tx_pattern();
        bit ok = 1'b1;
        logic exp_f;
        do_reset();
        // do_reset leaves us one edge after release: frame has toggled once.
        exp_f = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (tx_train_frame !== exp_f || tx_train_d !== (exp_f ? PAT : ~PAT)) ok = 1'b0;
            @(negedge clk);
            exp_f = ~exp_f;
        end
        checks++; if (!ok) begin errors++; $display("FAIL tx_pattern: frame=%b d=%h expected alternating %h/%h", tx_train_frame, tx_train_d, PAT, ~PAT); end
        // Without lock nothing should ever finish.
        checks++; if (train_done !== 1'b0 || train_fail !== 1'b0 || tx_src !== 1'b0) begin
            errors++; $display("FAIL no_lock_idle: done=%b fail=%b tx_src=%b expected 0 0 0", train_done, train_fail, tx_src);
        end
    endtask

    task automatic run_case(input string name, input logic [7:0] bad, input logic [7:0] mode,
                            input int exp_tap, input bit exp_ok);
        int cyc;
        bit to;
        do_reset();
        bad_mask = bad;
        bad_mode = mode;
        locked   = 1'b1;
        wait_end(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL %s_timeout: got no done/fail expected one within 400 cycles", name); end
        checks++; if (train_done !== exp_ok) begin errors++; $display("FAIL %s_done: got %b expected %b", name, train_done, exp_ok); end
        checks++; if (train_fail !== !exp_ok) begin errors++; $display("FAIL %s_fail: got %b expected %b", name, train_fail, !exp_ok); end
        checks++; if (tx_src !== exp_ok) begin errors++; $display("FAIL %s_tx_src: got %b expected %b", name, tx_src, exp_ok); end
        checks++; if (int'(tap_sel) != exp_tap) begin errors++; $display("FAIL %s_tap: got %0d expected %0d", name, tap_sel, exp_tap); end
        checks++; if (cyc < MIN_TRAIN || cyc > MIN_TRAIN + SLACK) begin
            errors++; $display("FAIL %s_time: got %0d cycles expected %0d..%0d", name, cyc, MIN_TRAIN, MIN_TRAIN + SLACK);
        end
        repeat (6) @(negedge clk);
        checks++; if (int'(tap_sel) != exp_tap || train_done !== exp_ok || train_fail !== !exp_ok) begin
            errors++; $display("FAIL %s_hold: got tap=%0d done=%b fail=%b expected tap=%0d done=%b", name, tap_sel, train_done, train_fail, exp_tap, exp_ok);
        end
    endtask

    task automatic test_directed();
        run_case("clean",     8'h00, 8'h00, 3, 1'b1);
        run_case("edges_bad", 8'hC3, 8'h00, 3, 1'b1);
        run_case("first_run", 8'h19, 8'h00, 1, 1'b1);
        run_case("all_bad",   8'hFF, 8'hFF, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] bad, mode;
        int t;
        bit ok;
        for (int n = 0; n < 10; n++) begin
            bad  = 8'($urandom_range(0, 255));
            mode = 8'($urandom_range(0, 255));
            t = model_tap(bad, ok);
            run_case($sformatf("rand%0d", n), bad, mode, t, ok);
        end
    endtask

    task automatic test_lock_loss_check();
        bit found = 1'b0;
        bit hold_ok = 1'b1;
        bit saw0 = 1'b0;
        bit to = 1'b1;
        int cyc = 0;
        do_reset();
        locked = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tap_sel == 3'd4) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL ll_reach_tap4: got tap=%0d expected 4", tap_sel); end
        repeat (2) @(negedge clk);
        locked = 1'b0;
        @(negedge clk);
        locked = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cyc++;
            if (tap_sel !== 3'd4 || train_done !== 1'b0) hold_ok = 1'b0;
        end
        checks++; if (!hold_ok) begin errors++; $display("FAIL ll_tap_hold: got tap=%0d done=%b expected tap=4 done=0", tap_sel, train_done); end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cyc++;
            if (tap_sel == 3'd0) saw0 = 1'b1;
            if (train_done || train_fail) begin to = 1'b0; break; end
        end
        checks++; if (to) begin errors++; $display("FAIL ll_timeout: got no done expected done"); end
        checks++; if (!saw0) begin errors++; $display("FAIL ll_resweep: got no tap 0 expected resweep from tap 0"); end
        checks++; if (train_done !== 1'b1 || tap_sel !== 3'd3) begin
            errors++; $display("FAIL ll_result: got done=%b tap=%0d expected done=1 tap=3", train_done, tap_sel);
        end
        checks++; if (cyc < MIN_TRAIN) begin errors++; $display("FAIL ll_time: got %0d cycles expected >= %0d", cyc, MIN_TRAIN); end
    endtask

    task automatic test_lock_loss_done();
        int cyc;
        bit to;
        do_reset();
        locked = 1'b1;
        wait_end(cyc, to);
        checks++; if (to || train_done !== 1'b1) begin errors++; $display("FAIL lld_train: got done=%b expected 1", train_done); end
        locked = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (train_done !== 1'b1) begin errors++; $display("FAIL lld_sync_delay: got done=%b expected 1", train_done); end
        @(negedge clk);
        checks++; if (train_done !== 1'b0 || tx_src !== 1'b0 || train_fail !== 1'b0) begin
            errors++; $display("FAIL lld_drop: got done=%b tx_src=%b fail=%b expected 0 0 0", train_done, tx_src, train_fail);
        end
        repeat (10) @(negedge clk);
        checks++; if (tap_sel !== 3'd3 || train_done !== 1'b0) begin
            errors++; $display("FAIL lld_tap_hold: got tap=%0d done=%b expected tap=3 done=0", tap_sel, train_done);
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit found = 1'b0;
        do_reset();
        locked = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tap_sel == 3'd5) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL rms_reach: got tap=%0d expected 5", tap_sel); end
        reset_b = 1'b0;
        #1;
        checks++; if (tap_sel !== 3'd0 || tx_train_d !== 6'h00 || tx_train_frame !== 1'b0 || train_done !== 1'b0 || tx_src !== 1'b0) begin
            errors++; $display("FAIL rms_outputs: got tap=%0d d=%h frame=%b done=%b tx_src=%b expected all 0",
                               tap_sel, tx_train_d, tx_train_frame, train_done, tx_src);
        end
        @(negedge clk);
        reset_b = 1'b1;
    endtask

`ifdef LVDS_TRAIN_RETRAIN_EN
    task automatic test_retrain();
        int cyc;
        bit to;
        bit saw0 = 1'b0;
        bit dropped = 1'b0;
        bit found = 1'b0;
        do_reset();
        locked = 1'b1;
        wait_end(cyc, to);
        checks++; if (to || train_done !== 1'b1) begin errors++; $display("FAIL rt_first: got done=%b expected 1", train_done); end
        retrain = 1'b1;
        @(negedge clk);
        retrain = 1'b0;
        checks++; if (train_done !== 1'b0 || tx_src !== 1'b0) begin
            errors++; $display("FAIL rt_drop: got done=%b tx_src=%b expected 0 0", train_done, tx_src);
        end
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tap_sel == 3'd0) saw0 = 1'b1;
            if (train_done) begin to = 1'b0; break; end
        end
        checks++; if (to || !saw0 || tap_sel !== 3'd3) begin
            errors++; $display("FAIL rt_rerun: got done=%b saw_tap0=%b tap=%0d expected 1 1 3", train_done, saw0, tap_sel);
        end
        // Pulse while in SETTLE: must be ignored.
        do_reset();
        locked = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tap_sel == 3'd2) begin found = 1'b1; break; end
        end
        retrain = 1'b1;
        @(negedge clk);
        retrain = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (tap_sel < 3'd2) dropped = 1'b1;
            if (train_done) begin to = 1'b0; break; end
            @(negedge clk);
        end
        checks++; if (!found || to || dropped || tap_sel !== 3'd3) begin
            errors++; $display("FAIL rt_settle_ignored: got done=%b restarted=%b tap=%0d expected 1 0 3", train_done, dropped, tap_sel);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_tx_pattern();
        test_directed();
        test_random();
        test_lock_loss_check();
        test_lock_loss_done();
        test_reset_mid_sweep();
`ifdef LVDS_TRAIN_RETRAIN_EN
        test_retrain();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
